if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor of the single-entry IF/ID pipeline register.
- A DEPTH-entry instruction queue between fetch and decode, using a valid/ready handshake on both sides.
- Redirect flush drops all queued entries in one cycle.
- A saturating decode-stall counter feeds the hazard/perf logic.
- Lets fetch run ahead of a stalled decode stage instead of freezing the front end.

Parameters:
- XLEN, 32, width of PC.
- ILEN, 32, width of instruction word.
- DEPTH, 4, queue entries; power of two, >= 2.
- CNT_W, 3, width of stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  branch/jump redirect; discards all entries.
- if_valid  in  1  fetch presents an instruction this cycle.
- if_pc  in  XLEN  PC of presented instruction.
- if_inst  in  ILEN  presented instruction word.
- if_ready  out  1  queue can accept; combinational, equals (count < DEPTH).
- id_valid  out  1  head entry valid; combinational, equals (count != 0).
- id_pc  out  XLEN  head PC; zero when empty.
- id_inst  out  ILEN  head instruction; zero (bubble) when empty.
- id_ready  in  1  decode consumes head this cycle (driven as !stall[2]).
- count  out  $clog2(DEPTH+1)  current occupancy.
- stall_cnt  out  CNT_W  consecutive cycles the head has waited.

Behaviour:
- Storage:
  - DEPTH-entry circular buffer of {pc, inst}.
  - Write pointer wp and read pointer rp, each $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH naturally.
- Handshake events:
  - push = if_valid && if_ready.
  - pop = id_valid && id_ready.
  - Both are evaluated on the same posedge.
- Reset (rst=1 at posedge): wp=rp=0, count=0, stall_cnt=0.
  - Outputs after reset: id_valid=0, id_pc=0, id_inst=0, if_ready=1.
  - Reset overrides flush and any handshake, including mid-stream.
- Flush (rst=0, flush=1): same clearing as reset. Any push or pop in that cycle is ignored.
  - Storage contents need not be cleared.
  - Outputs show zero/bubble from the next cycle.
- Normal cycle (no rst, no flush):
  - push only: write mem[wp], wp+1, count+1.
  - pop only: rp+1, count-1.
  - push and pop together: both pointers advance, count unchanged. This is legal at any occupancy 1..DEPTH-1.
  - When full, if_ready=0, so a push cannot coincide.
  - When empty, id_valid=0, so a pop cannot occur; a push still succeeds.
- Latency:
  - An instruction pushed at edge N is visible on id_* after edge N.
  - There is no same-cycle fall-through when empty.
  - id_pc/id_inst are driven from mem[rp], gated to zero when count==0.
- Ordering: strict FIFO; no reordering, no duplication.
- stall_cnt, evaluated at each edge after rst/flush:
  - Cleared if pop or count==0.
  - Otherwise incremented if id_valid && !id_ready, saturating at 2^CNT_W-1 (no wrap).
  - Cleared by rst and flush.
- count is never greater than DEPTH; if_ready and id_valid derive only from count.

Test Plan:
- Reset, then push PC 0x100..0x10C (inst 0xA0..0xA3) with id_ready=0:
  - if_ready=0 after 4th push; count=4.
  - 5th if_valid is not accepted; stall_cnt counts 1,2,3 during the waiting cycles.
- From full, raise id_ready for 4 cycles with if_valid=0:
  - id_pc goes 0x100,0x104,0x108,0x10C.
  - Then id_valid=0, id_pc=0, id_inst=0, stall_cnt=0.
- Hold if_valid=1 and id_ready=1 continuously from empty:
  - Each instruction appears 1 cycle after push; count holds 1 in steady state.
  - 10 sequential PCs exit in order across pointer wrap.
- Fill 3 entries, then assert flush together with if_valid and id_ready:
  - Next cycle count=0, id_valid=0, if_ready=1; the pushed instruction is lost.
  - The following push 0x200 appears at the head.
- Hold one entry with id_ready=0 for 10 cycles, CNT_W=3:
  - stall_cnt reaches 7 and holds at 7; a pop clears it to 0.
- Assert rst mid-stream with count=2 and simultaneous push/pop:
  - Next cycle all outputs are at reset values; no stale entry resurfaces after subsequent pushes.

Source files
------------

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//
// A DEPTH-entry instruction queue that sits between fetch and decode. It
// replaces the single-entry IF/ID pipeline register. Fetch can keep running
// ahead while decode is stalled. Both sides use a valid/ready handshake. A
// branch/jump redirect (flush) empties the queue in one cycle. A saturating
// counter reports how many consecutive cycles the head entry has waited.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   flush      in   redirect; discards every queued entry
//   if_valid   in   fetch presents {if_pc, if_inst} this cycle
//   if_pc      in   PC of the presented instruction
//   if_inst    in   presented instruction word
//   if_ready   out  queue can accept (count < DEPTH)
//   id_valid   out  head entry valid (count != 0)
//   id_pc      out  head PC, zero when empty
//   id_inst    out  head instruction, zero (bubble) when empty
//   id_ready   in   decode consumes the head this cycle
//   count      out  current occupancy
//   stall_cnt  out  consecutive cycles the head has waited, saturating
// -----------------------------------------------------------------------------
module if_id_queue #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [ILEN-1:0]            if_inst,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [ILEN-1:0]            id_inst,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    // Circular buffer storage. The pointers wrap modulo DEPTH on their own
    // because DEPTH is a power of two.
    logic [XLEN-1:0]  r_mem_pc   [DEPTH];
    logic [ILEN-1:0]  r_mem_inst [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_push;
    logic w_pop;

    // The handshake flags depend only on occupancy. This keeps the ready/valid
    // paths short and free of any loop back through the inputs.
    assign if_ready = (r_count < OCC_FULL);
    assign id_valid = (r_count != '0);
    assign w_push   = if_valid && if_ready;
    assign w_pop    = id_valid && id_ready;

    assign count     = r_count;
    assign stall_cnt = r_stall_cnt;

    // Head data is gated to zero when the queue is empty. Decode then sees a
    // clean bubble instead of a stale slot.
    always_comb begin
        // NOTE: every output of a combinational block is given a default first,
        //       so no path through the block leaves it unassigned and infers a latch.
        id_pc   = '0;
        id_inst = '0;
        if (id_valid) begin
            id_pc   = r_mem_pc[r_rp];
            id_inst = r_mem_inst[r_rp];
        end
    end

    // NOTE: the storage array has no reset. Validity is tracked only by the
    //       pointers and the count, so clearing the array would add reset
    //       fan-out without changing any visible behaviour.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wp]   <= if_pc;
            r_mem_inst[r_wp] <= if_inst;
        end
    end

    // Control state. Reset takes priority over flush. Flush drops any push or
    // pop that would otherwise happen in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        //       register samples values from before the edge, whatever the statement order.
        if (rst || flush) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end

            // A simultaneous push and pop leaves the occupancy unchanged.
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_ONE;
                2'b01:   r_count <= r_count - OCC_ONE;
                default: r_count <= r_count;
            endcase

            // The counter measures how long the current head has been blocked.
            // It restarts whenever the head leaves or no head exists.
            if (w_pop || (r_count == '0)) begin
                r_stall_cnt <= '0;
            end else if (id_valid && !id_ready && (r_stall_cnt != STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + STALL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_queue
//
// Self-checking bench for if_id_queue with the default parameters
// (DEPTH=4, CNT_W=3). A scoreboard queue holds every instruction the queue
// should have accepted. Entries are pushed when a push handshake occurs and
// popped when decode consumes the head. Each scenario task compares the DUT
// outputs inline against the scoreboard and against constants from the
// scenario.
// -----------------------------------------------------------------------------
module tb_if_id_queue;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             if_valid;
    logic [XLEN-1:0]  if_pc;
    logic [ILEN-1:0]  if_inst;
    logic             if_ready;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [ILEN-1:0]  id_inst;
    logic             id_ready;
    logic [OCC_W-1:0] count;
    logic [CNT_W-1:0] stall_cnt;

    entry_t exp_q[$];
    int     m_stall;
    int     n_pass;
    int     n_total;

    if_id_queue #(
        .XLEN (XLEN),
        .ILEN (ILEN),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .count    (count),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst,
                         input logic rdy, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
    endtask

    // Advances one clock and updates the scoreboard from the stimulus that
    // was present at that edge. Outputs are then sampled 1 time unit later.
    task automatic tick();
        int   sz;
        logic m_push;
        logic m_pop;
        sz     = exp_q.size();
        m_push = if_valid && (sz < DEPTH);
        m_pop  = id_ready && (sz != 0);
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
            m_stall = 0;
        end else begin
            if (m_pop || sz == 0) m_stall = 0;
            else if (m_stall < STALL_MAX) m_stall++;
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({if_pc, if_inst});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        n_total++;
        if ({id_valid, if_ready, count, stall_cnt} !== {1'b0, 1'b1, OCC_W'(0), CNT_W'(0)})
            $display("FAIL reset_flags: id_valid=%0b if_ready=%0b count=%0d stall=%0d, required 0 1 0 0",
                     id_valid, if_ready, count, stall_cnt);
        else n_pass++;
        n_total++;
        if ({id_pc, id_inst} !== '0)
            $display("FAIL reset_data: id_pc=%h id_inst=%h, required 0 0", id_pc, id_inst);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, XLEN'(32'h100 + 4*i), ILEN'(32'hA0 + i), 1'b0, 1'b0);
            tick();
            n_total++;
            if (count !== OCC_W'(i+1) || stall_cnt !== CNT_W'(i))
                $display("FAIL fill_%0d: count=%0d stall=%0d, required %0d %0d", i, count, stall_cnt, i+1, i);
            else n_pass++;
        end
        n_total++;
        if (if_ready !== 1'b0)
            $display("FAIL full_if_ready: if_ready=%0b, required 0", if_ready);
        else n_pass++;
        // A fifth instruction must be refused while full.
        drive(1'b1, 32'h110, 32'hA4, 1'b0, 1'b0);
        tick();
        n_total++;
        if (count !== OCC_W'(DEPTH) || stall_cnt !== CNT_W'(4) || id_pc !== 32'h100)
            $display("FAIL full_reject: count=%0d stall=%0d id_pc=%h, required 4 4 00000100",
                     count, stall_cnt, id_pc);
        else n_pass++;
    endtask

    task automatic test_drain();
        entry_t exp;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            exp = exp_q[0];
            n_total++;
            if (id_valid !== 1'b1 || id_pc !== exp.pc || id_inst !== exp.inst || id_pc !== XLEN'(32'h100 + 4*i))
                $display("FAIL drain_%0d: valid=%0b pc=%h inst=%h, required 1 %h %h",
                         i, id_valid, id_pc, id_inst, exp.pc, exp.inst);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({id_valid, id_pc, id_inst, stall_cnt, count} !== '0)
            $display("FAIL drain_empty: valid=%0b pc=%h inst=%h stall=%0d count=%0d, required all 0",
                     id_valid, id_pc, id_inst, stall_cnt, count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        entry_t exp;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                exp = exp_q[0];
                n_total++;
                if (id_valid !== 1'b1 || id_pc !== exp.pc || id_inst !== exp.inst ||
                    id_pc !== XLEN'(32'h300 + 4*(i-1)) || count !== OCC_W'(1))
                    $display("FAIL b2b_%0d: valid=%0b pc=%h inst=%h count=%0d, required 1 %h %h 1",
                             i, id_valid, id_pc, id_inst, count, exp.pc, exp.inst);
                else n_pass++;
            end
            if (i < 10) drive(1'b1, XLEN'(32'h300 + 4*i), ILEN'(32'hB0 + i), 1'b1, 1'b0);
            else        drive(1'b0, '0, '0, 1'b1, 1'b0);
            tick();
        end
        n_total++;
        if (id_valid !== 1'b0 || count !== '0)
            $display("FAIL b2b_end: valid=%0b count=%0d, required 0 0", id_valid, count);
        else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, XLEN'(32'h400 + 4*i), ILEN'(32'hC0 + i), 1'b0, 1'b0);
            tick();
        end
        n_total++;
        if (count !== OCC_W'(3))
            $display("FAIL flush_prefill: count=%0d, required 3", count);
        else n_pass++;
        drive(1'b1, 32'h40C, 32'hC3, 1'b1, 1'b1);
        tick();
        n_total++;
        if ({count, id_valid, if_ready, id_pc, id_inst} !== {OCC_W'(0), 1'b0, 1'b1, XLEN'(0), ILEN'(0)})
            $display("FAIL flush_clear: count=%0d valid=%0b if_ready=%0b pc=%h inst=%h, required 0 0 1 0 0",
                     count, id_valid, if_ready, id_pc, id_inst);
        else n_pass++;
        drive(1'b1, 32'h200, 32'h22, 1'b0, 1'b0);
        tick();
        n_total++;
        if (id_pc !== 32'h200 || id_inst !== 32'h22 || count !== OCC_W'(1) || id_pc !== exp_q[0].pc)
            $display("FAIL flush_refill: pc=%h inst=%h count=%0d, required 00000200 00000022 1",
                     id_pc, id_inst, count);
        else n_pass++;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_stall_sat();
        int exp_s;
        drive(1'b1, 32'h500, 32'hD0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_s = (k < STALL_MAX) ? k : STALL_MAX;
            n_total++;
            if (stall_cnt !== CNT_W'(exp_s) || stall_cnt !== CNT_W'(m_stall))
                $display("FAIL stall_%0d: stall_cnt=%0d, required %0d", k, stall_cnt, exp_s);
            else n_pass++;
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        n_total++;
        if (stall_cnt !== '0 || count !== '0)
            $display("FAIL stall_clear: stall_cnt=%0d count=%0d, required 0 0", stall_cnt, count);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        entry_t exp;
        drive(1'b1, 32'h600, 32'hE0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h604, 32'hE1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h608, 32'hE2, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({id_valid, if_ready, count, stall_cnt, id_pc, id_inst} !==
            {1'b0, 1'b1, OCC_W'(0), CNT_W'(0), XLEN'(0), ILEN'(0)})
            $display("FAIL rst_mid: valid=%0b if_ready=%0b count=%0d stall=%0d pc=%h inst=%h, required reset values",
                     id_valid, if_ready, count, stall_cnt, id_pc, id_inst);
        else n_pass++;
        drive(1'b1, 32'h700, 32'hF0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h704, 32'hF1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (count !== OCC_W'(2))
            $display("FAIL rst_refill_count: count=%0d, required 2", count);
        else n_pass++;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp = exp_q[0];
            n_total++;
            if (id_pc !== exp.pc || id_inst !== exp.inst || id_pc !== XLEN'(32'h700 + 4*i))
                $display("FAIL rst_order_%0d: pc=%h inst=%h, required %h %h", i, id_pc, id_inst, exp.pc, exp.inst);
            else n_pass++;
            tick();
        end
        n_total++;
        if (id_valid !== 1'b0)
            $display("FAIL rst_drained: valid=%0b, required 0", id_valid);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_stall = 0;
        rst     = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_stall_sat();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
